nand_exerciser: RTL and testbench
=================================

# nand_exerciser

Digital stimulus/checker that sits directly upstream of the on-chip sky130 NAND2 cell under test: drives its A/B inputs through the four truth-table vectors, samples its Y output through a synchroniser after a programmable settle time, and compares against ~(A&B). Reports pass/fail, an error count and the first failing vector on dedicated outputs. Optional loop mode reruns continuously for soak testing.

## Interface

- SETTLE_CYCLES, default 2: cycles allowed for the DUT output to settle after each vector; legal range 1..255.
- COUNT_W, default 8: width of err_count and run_count.

- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low; sampled on rising clk
- ena  input  1  design enable; low aborts any run
- start  input  1  begin a run; sampled only in IDLE
- loop  input  1  1 = rerun automatically after each run
- y_in  input  1  NAND2 output (asynchronous to clk)
- a_out  output  1  NAND2 input A (registered)
- b_out  output  1  NAND2 input B (registered)
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse at end of each run
- pass  output  1  1 = last completed run had zero errors
- fail_seen  output  1  a mismatch has occurred since the last start
- fail_vec  output  2  {A,B} of first mismatch since start
- err_count  output  COUNT_W  mismatches since start; saturates at all-ones
- run_count  output  COUNT_W  completed runs since start; saturates

## Operation

- y_in passes through a 2-flop synchroniser (y_sync); only y_sync is compared.
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: a_out=b_out=0, busy=0. On start=1 and ena=1: clear err_count, run_count, fail_seen, fail_vec, pass; vector index v=0; go DRIVE.
- DRIVE (1 cycle): {a_out,b_out} <= v; settle counter loaded; go SETTLE.
- SETTLE: hold SETTLE_CYCLES+1 cycles (settle plus synchroniser latency); go CHECK.
- CHECK (1 cycle): mismatch if y_sync != ~(v[1]&v[0]). On mismatch: err_count+1 (saturating); if fail_seen=0, fail_vec<=v and fail_seen<=1. If v=3 go DONE, else v+1, go DRIVE.
- DONE (1 cycle): done=1; run_count+1 (saturating); pass<=(err_count==0 including this run's CHECK). If loop=1 and ena=1: v=0, go DRIVE, counters not cleared. Else go IDLE.
- Vector order fixed: 00, 01, 10, 11.
- start while busy: ignored. loop sampled only in DONE.
- ena=0 in any state: next edge -> IDLE, a_out=b_out=0, no done pulse; counts, pass, fail_* held.
- Reset (rst_n=0 at an edge, any state, including mid-run): all outputs 0, state IDLE, synchroniser flops 0.

## Timing

- Start accepted at edge Es; vector 0 appears on a_out/b_out at edge Es+1.
- Per-vector period P = SETTLE_CYCLES+3 cycles (DRIVE 1 + SETTLE S+1 + CHECK 1).
- Vector driven at edge E0: comparison uses y_in as sampled at edge E0+S. A DUT whose Y settles within S-1 full cycles after a_out/b_out change is guaranteed to pass.
- done pulses in the cycle after edge Es+1+4P; busy falls at the same time as done unless looping (busy stays high in loop mode).
- With S=2: P=5, done high after edge Es+21.
- err_count, fail_* update at the CHECK edge; pass, run_count at the DONE edge.

## Test plan

- Ideal zero-delay NAND model, S=2, start at edge 10 -> a_out/b_out sequence 00,01,10,11 each 5 cycles from edge 11; done pulse after edge 31; pass=1, err_count=0, run_count=1, fail_seen=0.
- y_in stuck at 1 -> err_count=1, fail_vec=2'b11, fail_seen=1, pass=0.
- y_in stuck at 0 -> err_count=3, fail_vec=2'b00, pass=0.
- Registered NAND model delayed d cycles, S=2: d=1 -> pass=1; d=3 -> err_count>=1, pass=0.
- loop=1, y_in stuck at 1, run 3 full runs then loop=0 -> run_count=4, err_count=4, busy low after 4th done; COUNT_W=2 variant saturates run_count and err_count at 3.
- Mid-run abort: ena=0 during vector 2 -> IDLE next edge, a_out=b_out=0, no done, err_count held; separately rst_n=0 mid-run -> all outputs 0 next edge; subsequent start runs normally; start pulses while busy have no effect.

Source files
------------

// File: rtl/nand_exerciser.sv
// nand_exerciser: drives the four NAND2 truth-table vectors into the cell under test,
// samples its synchronised output after a settle window and tallies mismatches.
module nand_exerciser #(
    parameter int SETTLE_CYCLES = 2,
    parameter int COUNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               loop,
    input  logic               y_in,
    output logic               a_out,
    output logic               b_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               fail_seen,
    output logic [1:0]         fail_vec,
    output logic [COUNT_W-1:0] err_count,
    output logic [COUNT_W-1:0] run_count
);
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);

    state_t     state;
    logic [1:0] v;
    logic [7:0] cnt;
    logic       sync1;
    logic       y_sync;
    logic       mismatch;

    assign mismatch = y_sync != ~(v[1] & v[0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            v         <= '0;
            cnt       <= '0;
            sync1     <= 1'b0;
            y_sync    <= 1'b0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_seen <= 1'b0;
            fail_vec  <= '0;
            err_count <= '0;
            run_count <= '0;
        end else begin
            sync1  <= y_in;
            y_sync <= sync1;
            done   <= 1'b0;
            if (!ena) begin
                state <= IDLE;
                a_out <= 1'b0;
                b_out <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        a_out <= 1'b0;
                        b_out <= 1'b0;
                        if (start) begin
                            err_count <= '0;
                            run_count <= '0;
                            fail_seen <= 1'b0;
                            fail_vec  <= '0;
                            pass      <= 1'b0;
                            v         <= '0;
                            busy      <= 1'b1;
                            state     <= DRIVE;
                        end
                    end
                    DRIVE: begin
                        {a_out, b_out} <= v;
                        cnt            <= SETTLE_LD;
                        state          <= SETTLE;
                    end
                    // counts SETTLE_LD..0: settle time plus one cycle of synchroniser latency
                    SETTLE: begin
                        if (cnt == 8'd0) state <= CHECK;
                        else cnt <= cnt - 8'd1;
                    end
                    CHECK: begin
                        if (mismatch) begin
                            if (err_count != '1) err_count <= err_count + 1'b1;
                            if (!fail_seen) begin
                                fail_seen <= 1'b1;
                                fail_vec  <= v;
                            end
                        end
                        if (v == 2'd3) state <= DONE;
                        else begin
                            v     <= v + 2'd1;
                            state <= DRIVE;
                        end
                    end
                    DONE: begin
                        done <= 1'b1;
                        if (run_count != '1) run_count <= run_count + 1'b1;
                        pass <= err_count == '0;
                        v    <= '0;
                        if (loop) state <= DRIVE;
                        else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nand_exerciser.sv
// tb_nand_exerciser: directed checks of the NAND exerciser against ideal, stuck,
// delayed NAND models, loop/saturation, abort, reset and start-while-busy.
module tb_nand_exerciser;
    logic       clk = 1'b0;
    logic       rst_n, ena, start, loop;
    logic       y_in;
    logic       a_out, b_out, busy, done, pass, fail_seen;
    logic [1:0] fail_vec;
    logic [7:0] err_count, run_count;
    logic       a2, b2, busy2, done2, pass2, fs2;
    logic [1:0] fv2, err2, run2;

    int         checks = 0;
    int         failures = 0;
    int         mode = 0;
    int         d = 1;
    int         seen;
    logic [7:0] dl = '1;

    always #5 clk = ~clk;

    nand_exerciser #(.SETTLE_CYCLES(2), .COUNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .loop(loop), .y_in(y_in),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
        .fail_seen(fail_seen), .fail_vec(fail_vec), .err_count(err_count), .run_count(run_count)
    );

    nand_exerciser #(.SETTLE_CYCLES(2), .COUNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .loop(loop), .y_in(y_in),
        .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_seen(fs2), .fail_vec(fv2), .err_count(err2), .run_count(run2)
    );

    // NAND models: 0 ideal, 1 stuck-at-1, 2 stuck-at-0, 3 registered with d-cycle delay
    always @(posedge clk) dl <= {dl[6:0], ~(a_out & b_out)};
    always @* y_in = mode == 0 ? ~(a_out & b_out) : mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : dl[d-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 1);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; loop = 1'b0;
        repeat (3) tick();
        chk("rst_ab", {a_out, b_out}, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", err_count, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // ideal NAND, exact timing
        start_run();
        chk("t1_busy_es", 32'(busy), 1);
        chk("t1_ab_es", {a_out, b_out}, 0);
        tick();
        chk("t1_v0", {a_out, b_out}, 0);
        repeat (5) tick();
        chk("t1_v1", {a_out, b_out}, 1);
        repeat (4) tick();
        chk("t1_v1_hold", {a_out, b_out}, 1);
        tick();
        chk("t1_v2", {a_out, b_out}, 2);
        repeat (5) tick();
        chk("t1_v3", {a_out, b_out}, 3);
        repeat (4) tick();
        chk("t1_done_early", 32'(done), 0);
        chk("t1_busy_early", 32'(busy), 1);
        tick();
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_fall", 32'(busy), 0);
        chk("t1_pass", 32'(pass), 1);
        chk("t1_err", err_count, 0);
        chk("t1_run", run_count, 1);
        chk("t1_fs", 32'(fail_seen), 0);
        tick();
        chk("t1_done_pulse", 32'(done), 0);

        // stuck at 1: only vector 11 fails
        mode = 1;
        repeat (3) tick();
        start_run();
        wait_done();
        chk("s1_err", err_count, 1);
        chk("s1_fv", fail_vec, 3);
        chk("s1_fs", 32'(fail_seen), 1);
        chk("s1_pass", 32'(pass), 0);

        // stuck at 0: vectors 00,01,10 fail
        mode = 2;
        repeat (3) tick();
        start_run();
        wait_done();
        chk("s0_err", err_count, 3);
        chk("s0_fv", fail_vec, 0);
        chk("s0_pass", 32'(pass), 0);
        chk("s0_run", run_count, 1);

        // delayed NAND
        mode = 3; d = 1;
        repeat (4) tick();
        start_run();
        wait_done();
        chk("d1_pass", 32'(pass), 1);
        chk("d1_err", err_count, 0);
        d = 3;
        repeat (4) tick();
        start_run();
        wait_done();
        chk("d3_pass", 32'(pass), 0);
        chk("d3_err", err_count, 1);

        // loop mode with saturation check on the narrow instance
        mode = 1; loop = 1'b1;
        repeat (3) tick();
        start_run();
        wait_done();
        chk("lp_busy_held", 32'(busy), 1);
        chk("lp_run1", run_count, 1);
        tick();
        wait_done();
        tick();
        wait_done();
        loop = 1'b0;
        tick();
        wait_done();
        chk("lp_busy_low", 32'(busy), 0);
        chk("lp_run", run_count, 4);
        chk("lp_err", err_count, 4);
        chk("lp_pass", 32'(pass), 0);
        chk("lp_run_sat", run2, 3);
        chk("lp_err_sat", err2, 3);

        // abort during vector 2
        mode = 2;
        repeat (3) tick();
        start_run();
        repeat (12) tick();
        chk("ab_v2", {a_out, b_out}, 2);
        chk("ab_err_pre", err_count, 2);
        ena = 1'b0;
        tick();
        chk("ab_ab", {a_out, b_out}, 0);
        chk("ab_busy", 32'(busy), 0);
        chk("ab_err", err_count, 2);
        chk("ab_fs", 32'(fail_seen), 1);
        seen = 0;
        repeat (10) begin
            tick();
            if (done) seen++;
        end
        ena = 1'b1;
        repeat (30) begin
            tick();
            if (done) seen++;
        end
        chk("ab_no_done", seen, 0);
        chk("ab_err_held", err_count, 2);
        chk("ab_run_held", run_count, 0);

        // reset mid-run
        start_run();
        repeat (12) tick();
        rst_n = 1'b0;
        tick();
        chk("mr_ab", {a_out, b_out}, 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_err", err_count, 0);
        chk("mr_fs", 32'(fail_seen), 0);
        chk("mr_fv", fail_vec, 0);
        rst_n = 1'b1;
        mode = 0;
        repeat (3) tick();

        // start pulses while busy must not disturb the run
        start_run();
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sb_v1", {a_out, b_out}, 1);
        repeat (8) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("sb_done_early", 32'(done), 0);
        tick();
        chk("sb_done", 32'(done), 1);
        chk("sb_pass", 32'(pass), 1);
        chk("sb_run", run_count, 1);
        chk("sb_err", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
